// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the RV32-subset control pipeline: opcode/funct3
// encodings, ALU-op and write-back-select encodings, the layout of the
// 12-bit control word and of the narrower M/W stage words, the all-zero
// bubble constant, and the main decoder function.
package ctrl_pkg;

    // Opcodes (instr[6:0]) and funct3 values (instr[14:12]) understood by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // ALU operation classes handed to the ALU decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Full control word, as held in F and D
    localparam int CW_WIDTH       = 12;
    localparam int CW_VALID       = 11;
    localparam int CW_REGWRITE    = 10;
    localparam int CW_MEMWRITE    = 9;
    localparam int CW_LOAD        = 8;
    localparam int CW_BYTE        = 7;
    localparam int CW_ALUSRC      = 6;
    localparam int CW_MEMTOREG_HI = 5;
    localparam int CW_MEMTOREG_LO = 4;
    localparam int CW_BRANCH      = 3;
    localparam int CW_JUMP        = 2;
    localparam int CW_ALUOP_HI    = 1;
    localparam int CW_ALUOP_LO    = 0;

    // First memory sub-stage keeps only what memory and write-back still need
    localparam int M_WIDTH       = 7;
    localparam int M_VALID       = 6;
    localparam int M_REGWRITE    = 5;
    localparam int M_MEMWRITE    = 4;
    localparam int M_LOAD        = 3;
    localparam int M_BYTE        = 2;
    localparam int M_MEMTOREG_HI = 1;
    localparam int M_MEMTOREG_LO = 0;

    // Later memory sub-stages and W keep only the write-back fields
    localparam int W_WIDTH       = 5;
    localparam int W_VALID       = 4;
    localparam int W_REGWRITE    = 3;
    localparam int W_BYTE        = 2;
    localparam int W_MEMTOREG_HI = 1;
    localparam int W_MEMTOREG_LO = 0;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    // A bubble is all zeros, so it can never write the register file or memory
    localparam ctrl_word_t BUBBLE = '0;

    // Main decoder. Any encoding it does not recognise comes back as BUBBLE,
    // so "illegal" is simply the absence of the valid bit.
    function automatic ctrl_word_t decodeCtrl(input logic [6:0] op, input logic [2:0] f3);
        ctrl_word_t w;
        w = BUBBLE;
        case (op)
            OP_LOAD: if (f3 == F3_BYTE || f3 == F3_WORD) begin
                w[CW_VALID]                       = 1'b1;
                w[CW_REGWRITE]                    = 1'b1;
                w[CW_LOAD]                        = 1'b1;
                w[CW_BYTE]                        = (f3 == F3_BYTE);
                w[CW_ALUSRC]                      = 1'b1;
                w[CW_MEMTOREG_HI:CW_MEMTOREG_LO]  = WB_MEM;
                w[CW_ALUOP_HI:CW_ALUOP_LO]        = ALU_ADD;
            end
            OP_STORE: if (f3 == F3_BYTE || f3 == F3_WORD) begin
                w[CW_VALID]                       = 1'b1;
                w[CW_MEMWRITE]                    = 1'b1;
                w[CW_BYTE]                        = (f3 == F3_BYTE);
                w[CW_ALUSRC]                      = 1'b1;
                w[CW_ALUOP_HI:CW_ALUOP_LO]        = ALU_ADD;
            end
            OP_RTYPE: if (f3 == F3_ADD) begin
                w[CW_VALID]                       = 1'b1;
                w[CW_REGWRITE]                    = 1'b1;
                w[CW_ALUOP_HI:CW_ALUOP_LO]        = ALU_RTYPE;
            end
            OP_IMM: if (f3 == F3_ADD) begin
                w[CW_VALID]                       = 1'b1;
                w[CW_REGWRITE]                    = 1'b1;
                w[CW_ALUSRC]                      = 1'b1;
                w[CW_ALUOP_HI:CW_ALUOP_LO]        = ALU_ADD;
            end
            OP_BRANCH: if (f3 == F3_BEQ) begin
                w[CW_VALID]                       = 1'b1;
                w[CW_BRANCH]                      = 1'b1;
                w[CW_ALUOP_HI:CW_ALUOP_LO]        = ALU_SUB;
            end
            OP_JAL: begin
                w[CW_VALID]                       = 1'b1;
                w[CW_REGWRITE]                    = 1'b1;
                w[CW_JUMP]                        = 1'b1;
                w[CW_MEMTOREG_HI:CW_MEMTOREG_LO]  = WB_PC4;
            end
            default: w = BUBBLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg
// One pipeline stage register for the control pipeline.
// Ports:
//   clk       core clock
//   reset     asynchronous active-low clear
//   i_en      1 = capture this cycle, 0 = hold
//   i_bubble  when capturing, load the all-zero bubble instead of i_d
//   i_d       next-stage control fields
//   o_q       registered control fields
module ctrl_stage_reg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Hold has priority over bubble so a frozen pipeline never loses a flush's victim early
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_bubble ? '0 : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Main decoder plus control pipeline D -> E -> M1..M{MEM_LAT} -> W.
// Optional build macro CTRL_PIPE_PERF_EN adds perf_bubbles, perf_flushes and
// perf_freeze 32-bit counters.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   ihit                fetched instruction valid
//   dhit                data cache hit; low freezes every stage
//   opcode, funct       instr[6:0], instr[14:12] of the fetched instruction
//   stall_d, flush_e    hazard-unit controls (flush wins over stall)
//   LoadD..validW       per-stage control outputs
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    input  logic       stall_d,
    input  logic       flush_e,
    output logic       LoadD,
    output logic       ByteD,
    output logic       BranchD,
    output logic       illegal_d,
    output logic       ALUSrcE,
    output logic       BranchE,
    output logic       JumpE,
    output logic [1:0] aluopE,
    output logic       MemWriteM,
    output logic       LoadM,
    output logic       ByteM,
    output logic       RegWriteW,
    output logic       ByteW,
    output logic [1:0] MemtoRegW,
    output logic       validD,
    output logic       validE,
    output logic       validW
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_freeze
`endif
);

    ctrl_word_t             w_decWord;
    ctrl_word_t             w_fetchWord;
    logic                   w_fetchIllegal;
    logic [CW_WIDTH:0]      w_dReg;
    ctrl_word_t             w_dWord;
    ctrl_word_t             w_eWord;
    logic [M_WIDTH-1:0]     w_m1In;
    logic [M_WIDTH-1:0]     w_m1Word;
    logic [W_WIDTH-1:0]     w_mTail [MEM_LAT];
    logic [W_WIDTH-1:0]     w_wWord;

    // Fetch slot: no instruction or an illegal one both become a bubble;
    // the illegal flag is only raised for a real fetch when trapping is on.
    assign w_decWord      = decodeCtrl(opcode, funct);
    assign w_fetchWord    = ihit ? w_decWord : BUBBLE;
    assign w_fetchIllegal = ihit & ~w_decWord[CW_VALID] & (ILLEGAL_TRAP != 0);

    // D holds on stall unless a flush is also present, since the flush kills it anyway
    ctrl_stage_reg #(.WIDTH(CW_WIDTH + 1)) u_dStage (
        .clk      (clk),
        .reset    (reset),
        .i_en     (dhit & (flush_e | ~stall_d)),
        .i_bubble (flush_e),
        .i_d      ({w_fetchIllegal, w_fetchWord}),
        .o_q      (w_dReg)
    );
    assign w_dWord = w_dReg[CW_WIDTH-1:0];

    ctrl_stage_reg #(.WIDTH(CW_WIDTH)) u_eStage (
        .clk      (clk),
        .reset    (reset),
        .i_en     (dhit),
        .i_bubble (flush_e | stall_d),
        .i_d      (w_dWord),
        .o_q      (w_eWord)
    );

    assign w_m1In = {w_eWord[CW_VALID], w_eWord[CW_REGWRITE], w_eWord[CW_MEMWRITE],
                     w_eWord[CW_LOAD], w_eWord[CW_BYTE],
                     w_eWord[CW_MEMTOREG_HI:CW_MEMTOREG_LO]};

    ctrl_stage_reg #(.WIDTH(M_WIDTH)) u_m1Stage (
        .clk      (clk),
        .reset    (reset),
        .i_en     (dhit),
        .i_bubble (1'b0),
        .i_d      (w_m1In),
        .o_q      (w_m1Word)
    );

    // Memory access finishes in M1, so the remaining sub-stages only carry write-back fields
    assign w_mTail[0] = {w_m1Word[M_VALID], w_m1Word[M_REGWRITE], w_m1Word[M_BYTE],
                         w_m1Word[M_MEMTOREG_HI:M_MEMTOREG_LO]};

    genvar g;
    generate
        for (g = 1; g < MEM_LAT; g++) begin : g_mStage
            ctrl_stage_reg #(.WIDTH(W_WIDTH)) u_mStage (
                .clk      (clk),
                .reset    (reset),
                .i_en     (dhit),
                .i_bubble (1'b0),
                .i_d      (w_mTail[g-1]),
                .o_q      (w_mTail[g])
            );
        end
    endgenerate

    ctrl_stage_reg #(.WIDTH(W_WIDTH)) u_wStage (
        .clk      (clk),
        .reset    (reset),
        .i_en     (dhit),
        .i_bubble (1'b0),
        .i_d      (w_mTail[MEM_LAT-1]),
        .o_q      (w_wWord)
    );

    assign illegal_d = w_dReg[CW_WIDTH];
    assign validD    = w_dWord[CW_VALID];
    assign LoadD     = w_dWord[CW_LOAD];
    assign ByteD     = w_dWord[CW_BYTE];
    assign BranchD   = w_dWord[CW_BRANCH];

    assign validE    = w_eWord[CW_VALID];
    assign ALUSrcE   = w_eWord[CW_ALUSRC];
    assign BranchE   = w_eWord[CW_BRANCH];
    assign JumpE     = w_eWord[CW_JUMP];
    assign aluopE    = w_eWord[CW_ALUOP_HI:CW_ALUOP_LO];

    assign MemWriteM = w_m1Word[M_MEMWRITE];
    assign LoadM     = w_m1Word[M_LOAD];
    assign ByteM     = w_m1Word[M_BYTE];

    assign validW    = w_wWord[W_VALID];
    assign RegWriteW = w_wWord[W_REGWRITE];
    assign ByteW     = w_wWord[W_BYTE];
    assign MemtoRegW = w_wWord[W_MEMTOREG_HI:W_MEMTOREG_LO];

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] r_perfBubbles;
    logic [31:0] r_perfFlushes;
    logic [31:0] r_perfFreeze;

    // Bubbles and flushes only count when the pipeline actually moves
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perfBubbles <= '0;
            r_perfFlushes <= '0;
            r_perfFreeze  <= '0;
        end else if (!dhit) begin
            r_perfFreeze <= r_perfFreeze + 32'd1;
        end else begin
            if (stall_d | flush_e) begin
                r_perfBubbles <= r_perfBubbles + 32'd1;
            end
            if (flush_e) begin
                r_perfFlushes <= r_perfFlushes + 32'd1;
            end
        end
    end

    assign perf_bubbles = r_perfBubbles;
    assign perf_flushes = r_perfFlushes;
    assign perf_freeze  = r_perfFreeze;
`endif

endmodule
